// File: rtl/meanshift_win_ctrl.sv
// meanshift_win_ctrl: iteration controller that closes the meanshift loop.
// Each pass is launched with m_en. When m_done arrives the window is re-centred
// on the reported centroid and clamped to the frame. The request then ends as
// converged, lost, or out of passes after MAX_ITER launches.
// Optional feature: define MSWIN_WATCHDOG_EN to abort a pass that does not
// report m_done within TIMEOUT cycles of its launch.
module meanshift_win_ctrl #(
    parameter int FRAME_W  = 1280,
    parameter int FRAME_H  = 720,
    parameter int MAX_ITER = 10,
    parameter int EPS      = 1,
    parameter int M00_MIN  = 16,
    parameter int TIMEOUT  = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] r_min_i,
    input  logic [10:0] r_max_i,
    input  logic [10:0] c_min_i,
    input  logic [10:0] c_max_i,
    input  logic        m_done,
    input  logic [10:0] cen_x,
    input  logic [10:0] cen_y,
    input  logic [21:0] m_00,
    output logic        m_en,
    output logic [10:0] r_min,
    output logic [10:0] r_max,
    output logic [10:0] c_min,
    output logic [10:0] c_max,
    output logic        busy,
    output logic        track_done,
    output logic        converged,
    output logic        lost,
    output logic [3:0]  iter_cnt,
    output logic [10:0] obj_x,
    output logic [10:0] obj_y
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_LAUNCH, S_WAIT, S_UPDATE, S_FINISH
    } state_t;

    typedef struct packed {
        logic [10:0] lo;
        logic [10:0] hi;
    } span_t;

    localparam logic [10:0]        X_LAST    = 11'(FRAME_W - 1);
    localparam logic [10:0]        Y_LAST    = 11'(FRAME_H - 1);
    localparam logic signed [12:0] EPS_S     = 13'(EPS);
    localparam logic [21:0]        M00_LIM   = 22'(M00_MIN);
    localparam logic [3:0]         ITER_LAST = 4'(MAX_ITER);

    // Signed distance of a centroid coordinate from the window centre.
    // 13 bits keep every intermediate below from wrapping.
    function automatic logic signed [12:0] offset(input logic [10:0] lo, input logic [10:0] hi,
                                                  input logic [10:0] cen);
        logic signed [12:0] w;
        w = $signed({2'b00, hi}) - $signed({2'b00, lo});
        return $signed({2'b00, cen}) - ($signed({2'b00, lo}) + (w >>> 1));
    endfunction

    // Window centre, used for the reported object position.
    function automatic logic [10:0] centre(input logic [10:0] lo, input logic [10:0] hi);
        logic signed [12:0] w;
        logic signed [12:0] c;
        w = $signed({2'b00, hi}) - $signed({2'b00, lo});
        c = $signed({2'b00, lo}) + (w >>> 1);
        return 11'(c);
    endfunction

    // Move a span so that it is centred on cen. Keep its width, and pin it
    // against the frame edge at 0 or at last.
    function automatic span_t recentre(input logic [10:0] lo, input logic [10:0] hi,
                                       input logic [10:0] cen, input logic [10:0] last);
        logic signed [12:0] w, hw, c, lim, nlo, nhi;
        span_t s;
        w   = $signed({2'b00, hi}) - $signed({2'b00, lo});
        hw  = w >>> 1;
        c   = $signed({2'b00, cen});
        lim = $signed({2'b00, last});
        if (c < hw) begin
            nlo = '0;
            nhi = w;
        end else if (c - hw + w > lim) begin
            nhi = lim;
            nlo = lim - w;
        end else begin
            nlo = c - hw;
            nhi = nlo + w;
        end
        s.lo = 11'(nlo);
        s.hi = 11'(nhi);
        return s;
    endfunction

    state_t             state, state_n;
    logic [10:0]        r_min_n, r_max_n, c_min_n, c_max_n;
    logic [10:0]        obj_x_n, obj_y_n;
    logic               converged_n, lost_n;
    logic [3:0]         iter_n;
    logic [10:0]        cen_x_q, cen_y_q;
    logic               m00_low_q;
    span_t              col_s, row_s;
    logic signed [12:0] dx, dy;

`ifdef MSWIN_WATCHDOG_EN
    localparam logic [20:0] WD_LAST = 21'(TIMEOUT - 1);
    logic [20:0] wd_cnt;

    // Watchdog: count the cycles spent in WAIT, restarting at every launch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    wd_cnt <= '0;
        else if (state == S_LAUNCH) wd_cnt <= '0;
        else if (state == S_WAIT)   wd_cnt <= wd_cnt + 21'd1;
    end
`endif

    // Capture the centroid results of a pass when m_done arrives, so that
    // UPDATE does not depend on the inputs being held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cen_x_q   <= '0;
            cen_y_q   <= '0;
            m00_low_q <= 1'b0;
        end else if (state == S_WAIT && m_done) begin
            cen_x_q   <= cen_x;
            cen_y_q   <= cen_y;
            m00_low_q <= (m_00 < M00_LIM);
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            r_min     <= '0;
            r_max     <= '0;
            c_min     <= '0;
            c_max     <= '0;
            converged <= 1'b0;
            lost      <= 1'b0;
            iter_cnt  <= '0;
            obj_x     <= '0;
            obj_y     <= '0;
        end else begin
            state     <= state_n;
            r_min     <= r_min_n;
            r_max     <= r_max_n;
            c_min     <= c_min_n;
            c_max     <= c_max_n;
            converged <= converged_n;
            lost      <= lost_n;
            iter_cnt  <= iter_n;
            obj_x     <= obj_x_n;
            obj_y     <= obj_y_n;
        end
    end

    // Next-state, next-window and strobe decode.
    always_comb begin
        // NOTE: every signal driven here is given a default first, so no path
        // infers a latch. Blocking '=' is used here and '<=' only in always_ff.
        state_n     = state;
        r_min_n     = r_min;
        r_max_n     = r_max;
        c_min_n     = c_min;
        c_max_n     = c_max;
        converged_n = converged;
        lost_n      = lost;
        iter_n      = iter_cnt;
        obj_x_n     = obj_x;
        obj_y_n     = obj_y;
        m_en        = 1'b0;
        track_done  = 1'b0;
        busy        = (state != S_IDLE);
        col_s       = recentre(c_min, c_max, cen_x_q, X_LAST);
        row_s       = recentre(r_min, r_max, cen_y_q, Y_LAST);
        dx          = offset(c_min, c_max, cen_x_q);
        dy          = offset(r_min, r_max, cen_y_q);

        case (state)
            S_IDLE: begin
                if (start) state_n = S_LOAD;
            end
            S_LOAD: begin
                c_min_n     = c_min_i;
                c_max_n     = (c_max_i > X_LAST) ? X_LAST : c_max_i;
                r_min_n     = r_min_i;
                r_max_n     = (r_max_i > Y_LAST) ? Y_LAST : r_max_i;
                converged_n = 1'b0;
                lost_n      = 1'b0;
                iter_n      = '0;
                if (c_min_i > c_max_i || r_min_i > r_max_i) begin
                    lost_n  = 1'b1;
                    state_n = S_FINISH;
                end else begin
                    state_n = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                m_en    = 1'b1;
                iter_n  = iter_cnt + 4'd1;
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (m_done) state_n = S_UPDATE;
`ifdef MSWIN_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    lost_n  = 1'b1;
                    state_n = S_FINISH;
                end
`endif
            end
            S_UPDATE: begin
                if (m00_low_q) begin
                    lost_n  = 1'b1;
                    state_n = S_FINISH;
                end else if (dx <= EPS_S && dx >= -EPS_S && dy <= EPS_S && dy >= -EPS_S) begin
                    converged_n = 1'b1;
                    state_n     = S_FINISH;
                end else begin
                    c_min_n = col_s.lo;
                    c_max_n = col_s.hi;
                    r_min_n = row_s.lo;
                    r_max_n = row_s.hi;
                    state_n = (iter_cnt == ITER_LAST) ? S_FINISH : S_LAUNCH;
                end
            end
            S_FINISH: begin
                track_done = 1'b1;
                state_n    = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Object position comes from the final window and is valid while track_done is high.
        if (state_n == S_FINISH) begin
            obj_x_n = centre(c_min_n, c_max_n);
            obj_y_n = centre(r_min_n, r_max_n);
        end
    end

endmodule

// File: tb/tb_meanshift_win_ctrl.sv
// Self-checking bench for meanshift_win_ctrl. The bench acts as the meanshift
// stage and compares every launched window with a queue of expected windows.
// Per-request outcomes come from a hand-derived table.
module tb_meanshift_win_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] r_min_i, r_max_i, c_min_i, c_max_i;
    logic        m_done;
    logic [10:0] cen_x, cen_y;
    logic [21:0] m_00;
    logic        m_en;
    logic [10:0] r_min, r_max, c_min, c_max;
    logic        busy, track_done, converged, lost;
    logic [3:0]  iter_cnt;
    logic [10:0] obj_x, obj_y;

    always #5 clk = ~clk;

    meanshift_win_ctrl #(.TIMEOUT(100)) dut (
        .clk(clk), .rst(rst), .start(start),
        .r_min_i(r_min_i), .r_max_i(r_max_i), .c_min_i(c_min_i), .c_max_i(c_max_i),
        .m_done(m_done), .cen_x(cen_x), .cen_y(cen_y), .m_00(m_00),
        .m_en(m_en), .r_min(r_min), .r_max(r_max), .c_min(c_min), .c_max(c_max),
        .busy(busy), .track_done(track_done), .converged(converged), .lost(lost),
        .iter_cnt(iter_cnt), .obj_x(obj_x), .obj_y(obj_y)
    );

    // One tracking request and the outcome it must produce.
    typedef struct packed {
        int c_min; int c_max; int r_min; int r_max;
        int rel;   int cx;    int cy;    int m00;   int noise;
        int e_conv; int e_lost; int e_iter; int e_ox; int e_oy;
        int e_cmin; int e_cmax; int e_rmin; int e_rmax;
    } vec_t;

    typedef struct packed {
        int c_min; int c_max; int r_min; int r_max;
    } win_t;

    vec_t vecs[11];
    win_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] win_bits(input win_t w);
        return 64'({11'(w.c_min), 11'(w.c_max), 11'(w.r_min), 11'(w.r_max)});
    endfunction

    function automatic logic [63:0] dut_win();
        return 64'({c_min, c_max, r_min, r_max});
    endfunction

    function automatic int iabs(input int a);
        return (a < 0) ? -a : a;
    endfunction

    // Reference re-centring: put the span start at cen - w/2, then clamp it to [0, last - w].
    function automatic int new_lo(input int lo, input int hi, input int cen, input int last);
        int w;
        int nlo;
        w   = hi - lo;
        nlo = cen - w / 2;
        if (nlo < 0) nlo = 0;
        if (nlo + w > last) nlo = last - w;
        return nlo;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        m_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, 64'({m_en, busy, track_done, converged, lost, iter_cnt}), 64'(0));
        check({tag, "_win"}, dut_win(), 64'(0));
        check({tag, "_obj"}, 64'({obj_x, obj_y}), 64'(0));
    endtask

    task automatic run_request(input vec_t v);
        win_t cur;
        int   passes, fin, abort, w, h, ccx, ccy, cx, cy;
        cur.c_min = v.c_min;
        cur.c_max = (v.c_max > 1279) ? 1279 : v.c_max;
        cur.r_min = v.r_min;
        cur.r_max = (v.r_max > 719) ? 719 : v.r_max;
        passes = 0;
        fin = 0;
        abort = 0;
        tick();
        c_min_i = 11'(v.c_min);
        c_max_i = 11'(v.c_max);
        r_min_i = 11'(v.r_min);
        r_max_i = 11'(v.r_max);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_in_load", 64'(busy), 64'(1));
        tick();
        if (v.c_min > v.c_max || v.r_min > v.r_max) begin
            check("invalid_no_m_en", 64'(m_en), 64'(0));
            fin = 1;
        end else begin
            sb.push_back(cur);
        end
        while (fin == 0 && abort == 0) begin
            check("m_en_on_time", 64'(m_en), 64'(1));
            if (m_en !== 1'b1 || sb.size() == 0) begin
                abort = 1;
            end else begin
                check("win_at_launch", dut_win(), win_bits(sb.pop_front()));
                passes++;
                if (v.noise != 0) begin
                    m_done = 1'b1;
                    cen_x = '0;
                    cen_y = '0;
                    m_00 = '0;
                end
                tick();
                m_done = 1'b0;
                check("m_en_one_cycle", 64'(m_en), 64'(0));
                check("iter_cnt_in_wait", 64'(iter_cnt), 64'(passes));
                tick();
                check("win_stable_wait", dut_win(), win_bits(cur));
                w = cur.c_max - cur.c_min;
                h = cur.r_max - cur.r_min;
                ccx = cur.c_min + w / 2;
                ccy = cur.r_min + h / 2;
                cx = (v.rel != 0) ? ccx + v.cx : v.cx;
                cy = (v.rel != 0) ? ccy + v.cy : v.cy;
                m_done = 1'b1;
                cen_x = 11'(cx);
                cen_y = 11'(cy);
                m_00 = 22'(v.m00);
                if (v.noise != 0) start = 1'b1;
                tick();
                m_done = 1'b0;
                start = 1'b0;
                cen_x = '0;
                cen_y = '0;
                m_00 = '0;
                if (v.m00 < 16) begin
                    fin = 1;
                end else if (iabs(cx - ccx) <= 1 && iabs(cy - ccy) <= 1) begin
                    fin = 1;
                end else begin
                    cur.c_min = new_lo(cur.c_min, cur.c_max, cx, 1279);
                    cur.c_max = cur.c_min + w;
                    cur.r_min = new_lo(cur.r_min, cur.r_max, cy, 719);
                    cur.r_max = cur.r_min + h;
                    if (passes == 10) fin = 1;
                    else sb.push_back(cur);
                end
                tick();
                if (fin != 0) check("no_m_en_at_finish", 64'(m_en), 64'(0));
            end
        end
        if (abort == 0) begin
            check("track_done", 64'(track_done), 64'(1));
            check("converged", 64'(converged), 64'(v.e_conv));
            check("lost", 64'(lost), 64'(v.e_lost));
            check("iter_cnt", 64'(iter_cnt), 64'(v.e_iter));
            check("obj_x", 64'(obj_x), 64'(v.e_ox));
            check("obj_y", 64'(obj_y), 64'(v.e_oy));
            check("final_win", dut_win(),
                  64'({11'(v.e_cmin), 11'(v.e_cmax), 11'(v.e_rmin), 11'(v.e_rmax)}));
            check("sb_drained", 64'(sb.size()), 64'(0));
            if (v.noise != 0) start = 1'b1;
            tick();
            start = 1'b0;
            check("track_done_one_cycle", 64'(track_done), 64'(0));
            check("busy_clear", 64'(busy), 64'(0));
            if (v.noise != 0) begin
                tick();
                tick();
                check("start_at_done_ignored", 64'({busy, m_en}), 64'(0));
            end
        end
        if (abort != 0 || busy !== 1'b0) do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int seen;
        int n;
        //            c_min c_max r_min r_max rel  cx   cy   m00 noise conv lost iter  ox   oy  ecmin ecmax ermin ermax
        vecs[0]  = '{100,  163,  200,  263,  0,  131, 231, 1000, 1,  1,   0,   1,  131, 231, 100,  163,  200,  263};
        vecs[1]  = '{100,  163,  200,  263,  0,  150, 240, 1000, 0,  1,   0,   2,  150, 240, 119,  182,  209,  272};
        vecs[2]  = '{1200, 1263, 650,  713,  0, 1270, 715, 1000, 0,  0,   0,  10, 1247, 687, 1216, 1279, 656,  719};
        vecs[3]  = '{100,  163,  200,  263,  0,  131, 231,    5, 0,  0,   1,   1,  131, 231, 100,  163,  200,  263};
        vecs[4]  = '{500,  563,  300,  363,  1,   10,  10, 1000, 1,  0,   0,  10,  631, 431, 600,  663,  400,  463};
        vecs[5]  = '{10,   73,   5,    68,   0,    3,   2,  500, 0,  0,   0,  10,   31,  31,   0,   63,    0,   63};
        vecs[6]  = '{200,  100,  10,   20,   0,    0,   0, 1000, 0,  0,   1,   0,  150,  15, 200,  100,   10,   20};
        vecs[7]  = '{100,  163,  200,  263,  0,  132, 230,   16, 0,  1,   0,   1,  131, 231, 100,  163,  200,  263};
        vecs[8]  = '{100,  163,  200,  263,  0,  133, 231, 1000, 0,  1,   0,   2,  133, 231, 102,  165,  200,  263};
        vecs[9]  = '{100,  163,  200,  263,  0,  131, 231,   15, 0,  0,   1,   1,  131, 231, 100,  163,  200,  263};
        vecs[10] = '{1250, 1300, 700,  730,  0, 1264, 709, 1000, 0,  1,   0,   1, 1264, 709, 1250, 1279,  700,  719};

        rst = 1'b1;
        start = 1'b0;
        m_done = 1'b0;
        cen_x = '0;
        cen_y = '0;
        m_00 = '0;
        c_min_i = '0;
        c_max_i = '0;
        r_min_i = '0;
        r_max_i = '0;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        tick();
        check_all_zero("idle");

        for (int i = 0; i < 11; i++) run_request(vecs[i]);

        // Reset asserted mid-pass clears everything at once, and a late m_done launches nothing.
        tick();
        c_min_i = 11'd100;
        c_max_i = 11'd163;
        r_min_i = 11'd200;
        r_max_i = 11'd263;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("rst_seq_launch", 64'(m_en), 64'(1));
        tick();
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        #2 rst = 1'b0;
        tick();
        m_done = 1'b1;
        cen_x = 11'd150;
        cen_y = 11'd240;
        m_00 = 22'd1000;
        tick();
        m_done = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (m_en !== 1'b0 || busy !== 1'b0) seen++;
            tick();
        end
        check("no_m_en_after_rst", 64'(seen), 64'(0));

`ifdef MSWIN_WATCHDOG_EN
        // A withheld m_done is abandoned by the watchdog 101 cycles after the launch.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("wd_launch", 64'(m_en), 64'(1));
        n = 0;
        while (n < 200 && track_done !== 1'b1) begin
            tick();
            n++;
        end
        check("wd_done_latency", 64'(n), 64'(101));
        check("wd_lost", 64'(lost), 64'(1));
        check("wd_win_unchanged", dut_win(), 64'({11'd100, 11'd163, 11'd200, 11'd263}));
        tick();
`else
        n = 0;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
